// File: rtl/output_port_arbiter_pkg.sv
// NoC-wide constants shared by the router and its per-output-port arbiters.
package pa_noc;

  localparam int N_PORTS      = 5;
  localparam int PACKET_WIDTH = 32;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_e;

endpackage

// File: rtl/output_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  // Scan N candidates starting at ptr; the first hit wins and later hits are ignored.
  always_comb begin
    int cand;
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        index       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/output_port_arbiter.sv
// One output port of the router: round-robin pops one head packet per cycle
// into a single registered output slot, holding it under backpressure.
module output_port_arbiter
  import pa_noc::*;
#(
  parameter int N_REQ   = 5,
  parameter int STALL_W = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ*PACKET_WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]              o_pop,
  output logic [PACKET_WIDTH-1:0]       o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(N_REQ)-1:0]      o_grantIdx,
  output logic [STALL_W-1:0]            o_stallCount
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]           ptr_q, ptr_d;
  logic [PACKET_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [STALL_W-1:0]      stall_q, stall_d;

  logic [N_REQ-1:0]        grant;
  logic [IW-1:0]           sel_idx;
  logic                    any_req;
  logic                    slot_free;
  logic                    pop_en;
  logic [PACKET_WIDTH-1:0] sel_data;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req   (i_req),
    .ptr   (ptr_q),
    .grant (grant),
    .index (sel_idx),
    .any   (any_req)
  );

  assign slot_free = !valid_q || i_ready;
  // Reset gates the pop so no FIFO loses a packet while the slot is being cleared.
  assign pop_en    = slot_free && any_req && !i_rst;
  assign o_pop     = pop_en ? grant : '0;

  // Only the granted slice reaches the mux output, so X on idle inputs stays out.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) sel_data = i_data[k*PACKET_WIDTH +: PACKET_WIDTH];
    end
  end

  // Next-state for pointer, output slot and saturating stall counter.
  always_comb begin
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    stall_d = stall_q;
    if (pop_en) begin
      data_d  = sel_data;
      idx_d   = sel_idx;
      valid_d = 1'b1;
      ptr_d   = (sel_idx == IW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
    if (valid_q && !i_ready && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // State registers with synchronous reset; a held packet is simply discarded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      stall_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      stall_q <= stall_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_grantIdx   = idx_q;
  assign o_stallCount = stall_q;

endmodule
